// File: rtl/crossbar_pkg.sv
// ============================================================================
// crossbar_pkg
// Shared constants and helpers for the 2x2 crossbar.
// Optional feature macro used by the crossbar: CROSSBAR_CONFLICT_DET_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

package crossbar_pkg;

  localparam int NUM_MASTERS = 2;
  localparam int NUM_SLAVES  = 2;
  localparam int SEL_W       = 1;

  // Response encodings
  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] SLVERR = 2'd2;

  // True when both sources are enabled toward the same destination index.
  function automatic logic both_target(input logic             en0,
                                       input logic [SEL_W-1:0] sel0,
                                       input logic             en1,
                                       input logic [SEL_W-1:0] sel1,
                                       input int               dst);
    return en0 && en1 && (int'(sel0) == dst) && (int'(sel1) == dst);
  endfunction

endpackage

`default_nettype wire

// File: rtl/crossbar_2x2_if.sv
// ============================================================================
// crossbar_2x2_if
// One AXI-style port (AW, W, AR requests; B, R responses).
// 'master' drives requests, 'slave' drives responses and request readies.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface crossbar_2x2_if #(
  parameter int BUS_WIDTH  = 32,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32
);

  logic [ID_WIDTH-1:0]   AWID;
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic                  AWVALID;
  logic                  AWREADY;

  logic [BUS_WIDTH-1:0]  WDATA;
  logic                  WVALID;
  logic                  WREADY;

  logic [ID_WIDTH-1:0]   ARID;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic                  ARVALID;
  logic                  ARREADY;

  logic [ID_WIDTH-1:0]   BID;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;

  logic [ID_WIDTH-1:0]   RID;
  logic [BUS_WIDTH-1:0]  RDATA;
  logic [1:0]            RRESP;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output AWID, AWADDR, AWVALID, input AWREADY,
    output WDATA, WVALID,         input WREADY,
    output ARID, ARADDR, ARVALID, input ARREADY,
    input  BID, BRESP, BVALID,    output BREADY,
    input  RID, RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWVALID, output AWREADY,
    input  WDATA, WVALID,         output WREADY,
    input  ARID, ARADDR, ARVALID, output ARREADY,
    output BID, BRESP, BVALID,    input BREADY,
    output RID, RDATA, RRESP, RVALID, input RREADY
  );

endinterface

`default_nettype wire

// File: rtl/xbar_chan_mux.sv
// ============================================================================
// xbar_chan_mux
// Generic 2-source / 2-destination channel mux, fixed priority (source 0
// wins), purely combinational, outputs held at zero while reset is low.
// Revision: 1.0
// ============================================================================
`default_nettype none

module xbar_chan_mux
  import crossbar_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                              rst_ni,
  input  logic [NUM_MASTERS-1:0][W-1:0]     src_data_i,
  input  logic [NUM_MASTERS-1:0]            src_valid_i,
  input  logic [NUM_MASTERS-1:0]            src_en_i,
  input  logic [NUM_MASTERS-1:0][SEL_W-1:0] src_sel_i,
  output logic [NUM_MASTERS-1:0]            src_ready_o,
  output logic [NUM_SLAVES-1:0][W-1:0]      dst_data_o,
  output logic [NUM_SLAVES-1:0]             dst_valid_o,
  input  logic [NUM_SLAVES-1:0]             dst_ready_i
);

  // Per destination: source 0 first, then source 1; losers and unrouted
  // sources keep ready low, unrouted destinations stay all-zero.
  always_comb begin
    dst_data_o  = '0;
    dst_valid_o = '0;
    src_ready_o = '0;
    if (rst_ni) begin
      for (int d = 0; d < NUM_SLAVES; d++) begin
        if (src_en_i[0] && (int'(src_sel_i[0]) == d)) begin
          dst_data_o[d]  = src_data_i[0];
          dst_valid_o[d] = src_valid_i[0];
          src_ready_o[0] = dst_ready_i[d];
        end else if (src_en_i[1] && (int'(src_sel_i[1]) == d)) begin
          dst_data_o[d]  = src_data_i[1];
          dst_valid_o[d] = src_valid_i[1];
          src_ready_o[1] = dst_ready_i[d];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/crossbar_2x2.sv
// ============================================================================
// crossbar_2x2
// 2-master / 2-slave combinational crossbar with externally supplied routes.
// Optional macro CROSSBAR_CONFLICT_DET_EN adds sticky per-slave conflict flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module crossbar_2x2
  import crossbar_pkg::*;
#(
  parameter int BUS_WIDTH  = 32,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  crossbar_2x2_if.slave    M0,
  crossbar_2x2_if.slave    M1,
  crossbar_2x2_if.master   S0,
  crossbar_2x2_if.master   S1,
  input  logic [SEL_W-1:0] M0_write_addr_sel,
  input  logic             M0_write_addr_en,
  input  logic [SEL_W-1:0] M0_write_data_sel,
  input  logic             M0_write_data_en,
  input  logic [SEL_W-1:0] M0_read_addr_sel,
  input  logic             M0_read_addr_en,
  input  logic [SEL_W-1:0] M1_write_addr_sel,
  input  logic             M1_write_addr_en,
  input  logic [SEL_W-1:0] M1_write_data_sel,
  input  logic             M1_write_data_en,
  input  logic [SEL_W-1:0] M1_read_addr_sel,
  input  logic             M1_read_addr_en,
  input  logic [SEL_W-1:0] S0_write_resp_sel,
  input  logic             S0_write_resp_en,
  input  logic [SEL_W-1:0] S0_read_data_sel,
  input  logic             S0_read_data_en,
  input  logic [SEL_W-1:0] S1_write_resp_sel,
  input  logic             S1_write_resp_en,
  input  logic [SEL_W-1:0] S1_read_data_sel,
  input  logic             S1_read_data_en
`ifdef CROSSBAR_CONFLICT_DET_EN
  ,
  output logic             S0_conflict,
  output logic             S1_conflict
`endif
);

  localparam int AW_W = ID_WIDTH + ADDR_WIDTH;
  localparam int B_W  = ID_WIDTH + 2;
  localparam int R_W  = ID_WIDTH + BUS_WIDTH + 2;

  // ---------------- AW (master -> slave) ----------------
  logic [1:0][AW_W-1:0]  w_aw_src, w_aw_dst;
  logic [1:0][SEL_W-1:0] w_aw_sel;
  logic [1:0]            w_aw_ready;

  assign w_aw_src = {{M1.AWID, M1.AWADDR}, {M0.AWID, M0.AWADDR}};
  assign w_aw_sel = {M1_write_addr_sel, M0_write_addr_sel};
  assign {S0.AWID, S0.AWADDR} = w_aw_dst[0];
  assign {S1.AWID, S1.AWADDR} = w_aw_dst[1];
  assign M0.AWREADY = w_aw_ready[0];
  assign M1.AWREADY = w_aw_ready[1];

  xbar_chan_mux #(.W(AW_W)) u_aw (
    .rst_ni      (ARESETn),
    .src_data_i  (w_aw_src),
    .src_valid_i ({M1.AWVALID, M0.AWVALID}),
    .src_en_i    ({M1_write_addr_en, M0_write_addr_en}),
    .src_sel_i   (w_aw_sel),
    .src_ready_o (w_aw_ready),
    .dst_data_o  (w_aw_dst),
    .dst_valid_o ({S1.AWVALID, S0.AWVALID}),
    .dst_ready_i ({S1.AWREADY, S0.AWREADY})
  );

  // ---------------- W (master -> slave) ----------------
  logic [1:0][BUS_WIDTH-1:0] w_w_src, w_w_dst;
  logic [1:0][SEL_W-1:0]     w_w_sel;
  logic [1:0]                w_w_ready;

  assign w_w_src  = {M1.WDATA, M0.WDATA};
  assign w_w_sel  = {M1_write_data_sel, M0_write_data_sel};
  assign S0.WDATA = w_w_dst[0];
  assign S1.WDATA = w_w_dst[1];
  assign M0.WREADY = w_w_ready[0];
  assign M1.WREADY = w_w_ready[1];

  xbar_chan_mux #(.W(BUS_WIDTH)) u_w (
    .rst_ni      (ARESETn),
    .src_data_i  (w_w_src),
    .src_valid_i ({M1.WVALID, M0.WVALID}),
    .src_en_i    ({M1_write_data_en, M0_write_data_en}),
    .src_sel_i   (w_w_sel),
    .src_ready_o (w_w_ready),
    .dst_data_o  (w_w_dst),
    .dst_valid_o ({S1.WVALID, S0.WVALID}),
    .dst_ready_i ({S1.WREADY, S0.WREADY})
  );

  // ---------------- AR (master -> slave) ----------------
  logic [1:0][AW_W-1:0]  w_ar_src, w_ar_dst;
  logic [1:0][SEL_W-1:0] w_ar_sel;
  logic [1:0]            w_ar_ready;

  assign w_ar_src = {{M1.ARID, M1.ARADDR}, {M0.ARID, M0.ARADDR}};
  assign w_ar_sel = {M1_read_addr_sel, M0_read_addr_sel};
  assign {S0.ARID, S0.ARADDR} = w_ar_dst[0];
  assign {S1.ARID, S1.ARADDR} = w_ar_dst[1];
  assign M0.ARREADY = w_ar_ready[0];
  assign M1.ARREADY = w_ar_ready[1];

  xbar_chan_mux #(.W(AW_W)) u_ar (
    .rst_ni      (ARESETn),
    .src_data_i  (w_ar_src),
    .src_valid_i ({M1.ARVALID, M0.ARVALID}),
    .src_en_i    ({M1_read_addr_en, M0_read_addr_en}),
    .src_sel_i   (w_ar_sel),
    .src_ready_o (w_ar_ready),
    .dst_data_o  (w_ar_dst),
    .dst_valid_o ({S1.ARVALID, S0.ARVALID}),
    .dst_ready_i ({S1.ARREADY, S0.ARREADY})
  );

  // ---------------- B (slave -> master) ----------------
  logic [1:0][B_W-1:0]   w_b_src, w_b_dst;
  logic [1:0][SEL_W-1:0] w_b_sel;
  logic [1:0]            w_b_ready;

  assign w_b_src = {{S1.BID, S1.BRESP}, {S0.BID, S0.BRESP}};
  assign w_b_sel = {S1_write_resp_sel, S0_write_resp_sel};
  assign {M0.BID, M0.BRESP} = w_b_dst[0];
  assign {M1.BID, M1.BRESP} = w_b_dst[1];
  assign S0.BREADY = w_b_ready[0];
  assign S1.BREADY = w_b_ready[1];

  xbar_chan_mux #(.W(B_W)) u_b (
    .rst_ni      (ARESETn),
    .src_data_i  (w_b_src),
    .src_valid_i ({S1.BVALID, S0.BVALID}),
    .src_en_i    ({S1_write_resp_en, S0_write_resp_en}),
    .src_sel_i   (w_b_sel),
    .src_ready_o (w_b_ready),
    .dst_data_o  (w_b_dst),
    .dst_valid_o ({M1.BVALID, M0.BVALID}),
    .dst_ready_i ({M1.BREADY, M0.BREADY})
  );

  // ---------------- R (slave -> master) ----------------
  logic [1:0][R_W-1:0]   w_r_src, w_r_dst;
  logic [1:0][SEL_W-1:0] w_r_sel;
  logic [1:0]            w_r_ready;

  assign w_r_src = {{S1.RID, S1.RDATA, S1.RRESP}, {S0.RID, S0.RDATA, S0.RRESP}};
  assign w_r_sel = {S1_read_data_sel, S0_read_data_sel};
  assign {M0.RID, M0.RDATA, M0.RRESP} = w_r_dst[0];
  assign {M1.RID, M1.RDATA, M1.RRESP} = w_r_dst[1];
  assign S0.RREADY = w_r_ready[0];
  assign S1.RREADY = w_r_ready[1];

  xbar_chan_mux #(.W(R_W)) u_r (
    .rst_ni      (ARESETn),
    .src_data_i  (w_r_src),
    .src_valid_i ({S1.RVALID, S0.RVALID}),
    .src_en_i    ({S1_read_data_en, S0_read_data_en}),
    .src_sel_i   (w_r_sel),
    .src_ready_o (w_r_ready),
    .dst_data_o  (w_r_dst),
    .dst_valid_o ({M1.RVALID, M0.RVALID}),
    .dst_ready_i ({M1.RREADY, M0.RREADY})
  );

`ifdef CROSSBAR_CONFLICT_DET_EN
  logic [NUM_SLAVES-1:0] conflict_q, conflict_d;

  // Next state: a slave's flag latches once both masters aim any request
  // channel at it; only reset clears it.
  always_comb begin
    conflict_d = conflict_q;
    for (int j = 0; j < NUM_SLAVES; j++) begin
      if (both_target(M0_write_addr_en, M0_write_addr_sel,
                      M1_write_addr_en, M1_write_addr_sel, j) ||
          both_target(M0_write_data_en, M0_write_data_sel,
                      M1_write_data_en, M1_write_data_sel, j) ||
          both_target(M0_read_addr_en,  M0_read_addr_sel,
                      M1_read_addr_en,  M1_read_addr_sel,  j)) begin
        conflict_d[j] = 1'b1;
      end
    end
  end

  // Sticky conflict flag register, asynchronously cleared.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      conflict_q <= '0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign S0_conflict = conflict_q[0];
  assign S1_conflict = conflict_q[1];
`else
  // Without conflict detection the crossbar holds no state; the clock is
  // intentionally unused.
  logic w_unused_aclk;
  assign w_unused_aclk = ACLK;
`endif

endmodule

`default_nettype wire

// File: tb/tb_crossbar_2x2.sv
// ============================================================================
// tb_crossbar_2x2
// Self-checking bench for crossbar_2x2: directed table, hand-written reset and
// conflict sequences, and randomized traffic against a route-table model.
// Honours CROSSBAR_CONFLICT_DET_EN when defined.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_crossbar_2x2;
  import crossbar_pkg::*;

  logic ACLK    = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  crossbar_2x2_if #(.BUS_WIDTH(32), .ID_WIDTH(4), .ADDR_WIDTH(32)) m0(), m1(), s0(), s1();

  logic [0:0] M0_write_addr_sel, M0_write_data_sel, M0_read_addr_sel;
  logic [0:0] M1_write_addr_sel, M1_write_data_sel, M1_read_addr_sel;
  logic [0:0] S0_write_resp_sel, S0_read_data_sel, S1_write_resp_sel, S1_read_data_sel;
  logic M0_write_addr_en, M0_write_data_en, M0_read_addr_en;
  logic M1_write_addr_en, M1_write_data_en, M1_read_addr_en;
  logic S0_write_resp_en, S0_read_data_en, S1_write_resp_en, S1_read_data_en;
`ifdef CROSSBAR_CONFLICT_DET_EN
  logic S0_conflict, S1_conflict;
`endif

  crossbar_2x2 #(.BUS_WIDTH(32), .ID_WIDTH(4), .ADDR_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .M0(m0), .M1(m1), .S0(s0), .S1(s1),
    .M0_write_addr_sel(M0_write_addr_sel), .M0_write_addr_en(M0_write_addr_en),
    .M0_write_data_sel(M0_write_data_sel), .M0_write_data_en(M0_write_data_en),
    .M0_read_addr_sel(M0_read_addr_sel),   .M0_read_addr_en(M0_read_addr_en),
    .M1_write_addr_sel(M1_write_addr_sel), .M1_write_addr_en(M1_write_addr_en),
    .M1_write_data_sel(M1_write_data_sel), .M1_write_data_en(M1_write_data_en),
    .M1_read_addr_sel(M1_read_addr_sel),   .M1_read_addr_en(M1_read_addr_en),
    .S0_write_resp_sel(S0_write_resp_sel), .S0_write_resp_en(S0_write_resp_en),
    .S0_read_data_sel(S0_read_data_sel),   .S0_read_data_en(S0_read_data_en),
    .S1_write_resp_sel(S1_write_resp_sel), .S1_write_resp_en(S1_write_resp_en),
    .S1_read_data_sel(S1_read_data_sel),   .S1_read_data_en(S1_read_data_en)
`ifdef CROSSBAR_CONFLICT_DET_EN
    , .S0_conflict(S0_conflict), .S1_conflict(S1_conflict)
`endif
  );

  // Stimulus record: index [i] is the source (master for AW/W/AR, slave for B/R).
  typedef struct {
    logic [1:0] aw_en, aw_sel, w_en, w_sel, ar_en, ar_sel, b_en, b_sel, r_en, r_sel;
    logic [1:0] awvalid, wvalid, arvalid;
    logic [1:0][3:0]  awid, arid;
    logic [1:0][31:0] awaddr, araddr, wdata;
    logic [1:0] awready_s, wready_s, arready_s;
    logic [1:0] bvalid_s, rvalid_s;
    logic [1:0][3:0]  bid_s, rid_s;
    logic [1:0][1:0]  bresp_s, rresp_s;
    logic [1:0][31:0] rdata_s;
    logic [1:0] bready_m, rready_m;
  } stim_t;

  typedef struct {
    logic [1:0] s_awvalid, m_awready, s_wvalid, m_wready, s_arvalid, m_arready, m_rvalid, s_rready;
    logic [1:0][31:0] s_awaddr, s_wdata, s_araddr, m_rdata;
    logic [1:0][3:0]  m_rid;
  } exp_t;

  typedef struct {
    stim_t stim;
    exp_t  exp;
  } vec_t;

  localparam int NT = 8;
  vec_t  tbl [NT];
  stim_t cur;
  logic [1:0] exp_conf;
  int n_vec = 0;
  int n_err = 0;

  // Collected DUT outputs, index = port number
  logic [1:0] a_awready, a_wready, a_arready, a_bvalid, a_rvalid;
  logic [1:0] a_s_awvalid, a_s_wvalid, a_s_arvalid, a_s_bready, a_s_rready;
  logic [1:0][3:0]  a_bid, a_rid, a_s_awid, a_s_arid;
  logic [1:0][1:0]  a_bresp, a_rresp;
  logic [1:0][31:0] a_rdata, a_s_awaddr, a_s_wdata, a_s_araddr;
  assign a_awready   = {m1.AWREADY, m0.AWREADY};
  assign a_wready    = {m1.WREADY,  m0.WREADY};
  assign a_arready   = {m1.ARREADY, m0.ARREADY};
  assign a_bvalid    = {m1.BVALID,  m0.BVALID};
  assign a_rvalid    = {m1.RVALID,  m0.RVALID};
  assign a_bid       = {m1.BID,     m0.BID};
  assign a_rid       = {m1.RID,     m0.RID};
  assign a_bresp     = {m1.BRESP,   m0.BRESP};
  assign a_rresp     = {m1.RRESP,   m0.RRESP};
  assign a_rdata     = {m1.RDATA,   m0.RDATA};
  assign a_s_awvalid = {s1.AWVALID, s0.AWVALID};
  assign a_s_wvalid  = {s1.WVALID,  s0.WVALID};
  assign a_s_arvalid = {s1.ARVALID, s0.ARVALID};
  assign a_s_bready  = {s1.BREADY,  s0.BREADY};
  assign a_s_rready  = {s1.RREADY,  s0.RREADY};
  assign a_s_awid    = {s1.AWID,    s0.AWID};
  assign a_s_arid    = {s1.ARID,    s0.ARID};
  assign a_s_awaddr  = {s1.AWADDR,  s0.AWADDR};
  assign a_s_wdata   = {s1.WDATA,   s0.WDATA};
  assign a_s_araddr  = {s1.ARADDR,  s0.ARADDR};

  task automatic cmp(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] @%0t: got %h, expected %h", nm, idx, $time, act, exp);
    end
  endtask

  function automatic stim_t zs();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic exp_t ze();
    exp_t e;
    e = '{default: '0};
    return e;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.aw_en = 2'($urandom); s.aw_sel = 2'($urandom);
    s.w_en  = 2'($urandom); s.w_sel  = 2'($urandom);
    s.ar_en = 2'($urandom); s.ar_sel = 2'($urandom);
    s.b_en  = 2'($urandom); s.b_sel  = 2'($urandom);
    s.r_en  = 2'($urandom); s.r_sel  = 2'($urandom);
    s.awvalid = 2'($urandom); s.wvalid = 2'($urandom); s.arvalid = 2'($urandom);
    s.awready_s = 2'($urandom); s.wready_s = 2'($urandom); s.arready_s = 2'($urandom);
    s.bvalid_s = 2'($urandom); s.rvalid_s = 2'($urandom);
    s.bready_m = 2'($urandom); s.rready_m = 2'($urandom);
    for (int i = 0; i < 2; i++) begin
      s.awid[i] = 4'($urandom); s.arid[i] = 4'($urandom);
      s.awaddr[i] = $urandom; s.araddr[i] = $urandom; s.wdata[i] = $urandom;
      s.bid_s[i] = 4'($urandom); s.rid_s[i] = 4'($urandom);
      s.bresp_s[i] = 2'($urandom); s.rresp_s[i] = 2'($urandom);
      s.rdata_s[i] = $urandom;
    end
    return s;
  endfunction

  task automatic drive(input stim_t s);
    cur = s;
    m0.AWID = s.awid[0]; m0.AWADDR = s.awaddr[0]; m0.AWVALID = s.awvalid[0];
    m1.AWID = s.awid[1]; m1.AWADDR = s.awaddr[1]; m1.AWVALID = s.awvalid[1];
    m0.WDATA = s.wdata[0]; m0.WVALID = s.wvalid[0];
    m1.WDATA = s.wdata[1]; m1.WVALID = s.wvalid[1];
    m0.ARID = s.arid[0]; m0.ARADDR = s.araddr[0]; m0.ARVALID = s.arvalid[0];
    m1.ARID = s.arid[1]; m1.ARADDR = s.araddr[1]; m1.ARVALID = s.arvalid[1];
    m0.BREADY = s.bready_m[0]; m1.BREADY = s.bready_m[1];
    m0.RREADY = s.rready_m[0]; m1.RREADY = s.rready_m[1];
    s0.AWREADY = s.awready_s[0]; s1.AWREADY = s.awready_s[1];
    s0.WREADY  = s.wready_s[0];  s1.WREADY  = s.wready_s[1];
    s0.ARREADY = s.arready_s[0]; s1.ARREADY = s.arready_s[1];
    s0.BID = s.bid_s[0]; s0.BRESP = s.bresp_s[0]; s0.BVALID = s.bvalid_s[0];
    s1.BID = s.bid_s[1]; s1.BRESP = s.bresp_s[1]; s1.BVALID = s.bvalid_s[1];
    s0.RID = s.rid_s[0]; s0.RDATA = s.rdata_s[0]; s0.RRESP = s.rresp_s[0]; s0.RVALID = s.rvalid_s[0];
    s1.RID = s.rid_s[1]; s1.RDATA = s.rdata_s[1]; s1.RRESP = s.rresp_s[1]; s1.RVALID = s.rvalid_s[1];
    M0_write_addr_en = s.aw_en[0]; M0_write_addr_sel = s.aw_sel[0];
    M1_write_addr_en = s.aw_en[1]; M1_write_addr_sel = s.aw_sel[1];
    M0_write_data_en = s.w_en[0];  M0_write_data_sel = s.w_sel[0];
    M1_write_data_en = s.w_en[1];  M1_write_data_sel = s.w_sel[1];
    M0_read_addr_en  = s.ar_en[0]; M0_read_addr_sel  = s.ar_sel[0];
    M1_read_addr_en  = s.ar_en[1]; M1_read_addr_sel  = s.ar_sel[1];
    S0_write_resp_en = s.b_en[0];  S0_write_resp_sel = s.b_sel[0];
    S1_write_resp_en = s.b_en[1];  S1_write_resp_sel = s.b_sel[1];
    S0_read_data_en  = s.r_en[0];  S0_read_data_sel  = s.r_sel[0];
    S1_read_data_en  = s.r_en[1];  S1_read_data_sel  = s.r_sel[1];
  endtask

  // Reference: the lowest-numbered enabled source aimed at d owns d (-1: none).
  function automatic int owner(input logic [1:0] en, input logic [1:0] sel, input int d);
    if (!ARESETn) return -1;
    for (int i = 0; i < 2; i++)
      if (en[i] && int'(sel[i]) == d) return i;
    return -1;
  endfunction

  // Slaves that both masters aim at on some request channel.
  function automatic logic [1:0] conf_hit(input stim_t s);
    logic [1:0] h;
    h = '0;
    for (int j = 0; j < 2; j++)
      if ((s.aw_en == 2'b11 && int'(s.aw_sel[0]) == j && int'(s.aw_sel[1]) == j) ||
          (s.w_en  == 2'b11 && int'(s.w_sel[0])  == j && int'(s.w_sel[1])  == j) ||
          (s.ar_en == 2'b11 && int'(s.ar_sel[0]) == j && int'(s.ar_sel[1]) == j))
        h[j] = 1'b1;
    return h;
  endfunction

  task automatic check_model(input string tg);
    int o;
    int d;
    for (int j = 0; j < 2; j++) begin
      // destination side: slave j (requests), master j (responses)
      o = owner(cur.aw_en, cur.aw_sel, j);
      cmp({tg, " S_AWVALID"}, j, 64'(a_s_awvalid[j]), (o < 0) ? 64'd0 : 64'(cur.awvalid[o]));
      cmp({tg, " S_AWADDR"},  j, 64'(a_s_awaddr[j]),  (o < 0) ? 64'd0 : 64'(cur.awaddr[o]));
      cmp({tg, " S_AWID"},    j, 64'(a_s_awid[j]),    (o < 0) ? 64'd0 : 64'(cur.awid[o]));
      o = owner(cur.w_en, cur.w_sel, j);
      cmp({tg, " S_WVALID"},  j, 64'(a_s_wvalid[j]),  (o < 0) ? 64'd0 : 64'(cur.wvalid[o]));
      cmp({tg, " S_WDATA"},   j, 64'(a_s_wdata[j]),   (o < 0) ? 64'd0 : 64'(cur.wdata[o]));
      o = owner(cur.ar_en, cur.ar_sel, j);
      cmp({tg, " S_ARVALID"}, j, 64'(a_s_arvalid[j]), (o < 0) ? 64'd0 : 64'(cur.arvalid[o]));
      cmp({tg, " S_ARADDR"},  j, 64'(a_s_araddr[j]),  (o < 0) ? 64'd0 : 64'(cur.araddr[o]));
      cmp({tg, " S_ARID"},    j, 64'(a_s_arid[j]),    (o < 0) ? 64'd0 : 64'(cur.arid[o]));
      o = owner(cur.b_en, cur.b_sel, j);
      cmp({tg, " M_BVALID"},  j, 64'(a_bvalid[j]), (o < 0) ? 64'd0 : 64'(cur.bvalid_s[o]));
      cmp({tg, " M_BID"},     j, 64'(a_bid[j]),    (o < 0) ? 64'd0 : 64'(cur.bid_s[o]));
      cmp({tg, " M_BRESP"},   j, 64'(a_bresp[j]),  (o < 0) ? 64'd0 : 64'(cur.bresp_s[o]));
      o = owner(cur.r_en, cur.r_sel, j);
      cmp({tg, " M_RVALID"},  j, 64'(a_rvalid[j]), (o < 0) ? 64'd0 : 64'(cur.rvalid_s[o]));
      cmp({tg, " M_RDATA"},   j, 64'(a_rdata[j]),  (o < 0) ? 64'd0 : 64'(cur.rdata_s[o]));
      cmp({tg, " M_RID"},     j, 64'(a_rid[j]),    (o < 0) ? 64'd0 : 64'(cur.rid_s[o]));
      cmp({tg, " M_RRESP"},   j, 64'(a_rresp[j]),  (o < 0) ? 64'd0 : 64'(cur.rresp_s[o]));
      // source side: ready only for the owner of its chosen destination
      d = int'(cur.aw_sel[j]);
      cmp({tg, " M_AWREADY"}, j, 64'(a_awready[j]),
          (owner(cur.aw_en, cur.aw_sel, d) == j) ? 64'(cur.awready_s[d]) : 64'd0);
      d = int'(cur.w_sel[j]);
      cmp({tg, " M_WREADY"}, j, 64'(a_wready[j]),
          (owner(cur.w_en, cur.w_sel, d) == j) ? 64'(cur.wready_s[d]) : 64'd0);
      d = int'(cur.ar_sel[j]);
      cmp({tg, " M_ARREADY"}, j, 64'(a_arready[j]),
          (owner(cur.ar_en, cur.ar_sel, d) == j) ? 64'(cur.arready_s[d]) : 64'd0);
      d = int'(cur.b_sel[j]);
      cmp({tg, " S_BREADY"}, j, 64'(a_s_bready[j]),
          (owner(cur.b_en, cur.b_sel, d) == j) ? 64'(cur.bready_m[d]) : 64'd0);
      d = int'(cur.r_sel[j]);
      cmp({tg, " S_RREADY"}, j, 64'(a_s_rready[j]),
          (owner(cur.r_en, cur.r_sel, d) == j) ? 64'(cur.rready_m[d]) : 64'd0);
    end
  endtask

  // Advance one clock (stimulus is stable across the edge) and check flags.
  task automatic tick();
    if (ARESETn) exp_conf = exp_conf | conf_hit(cur);
    @(posedge ACLK);
    #1;
`ifdef CROSSBAR_CONFLICT_DET_EN
    cmp("conflict", 0, 64'({S1_conflict, S0_conflict}), 64'(exp_conf));
`endif
  endtask

  initial begin
    stim_t s;
    exp_t  e;

    // ---- directed table ----
    s = zs(); e = ze();
    s.aw_en = 2'b01; s.w_en = 2'b01; s.awvalid = 2'b01; s.wvalid = 2'b01;
    s.awaddr[0] = 32'hAABBCCDD; s.wdata[0] = 32'h12345678;
    s.awready_s = 2'b01; s.wready_s = 2'b01;
    e.s_awvalid = 2'b01; e.s_awaddr[0] = 32'hAABBCCDD; e.m_awready = 2'b01;
    e.s_wvalid = 2'b01; e.s_wdata[0] = 32'h12345678; e.m_wready = 2'b01;
    tbl[0].stim = s; tbl[0].exp = e;
    s.awvalid = 2'b00; s.wvalid = 2'b00;
    e.s_awvalid = 2'b00; e.s_wvalid = 2'b00;
    tbl[1].stim = s; tbl[1].exp = e;

    s = zs(); e = ze();
    s.ar_en = 2'b01; s.araddr[0] = 32'hDEADBEEF; s.arvalid = 2'b01; s.arready_s = 2'b01;
    e.s_arvalid = 2'b01; e.s_araddr[0] = 32'hDEADBEEF; e.m_arready = 2'b01;
    tbl[2].stim = s; tbl[2].exp = e;
    s.ar_en = 2'b00;
    tbl[3].stim = s; tbl[3].exp = ze();

    s = zs(); e = ze();
    s.aw_en = 2'b11; s.aw_sel = 2'b11; s.awvalid = 2'b11; s.awready_s = 2'b11;
    s.awaddr[0] = 32'h0000_2000; s.awaddr[1] = 32'h0000_1000;
    e.s_awvalid = 2'b10; e.s_awaddr[1] = 32'h0000_2000; e.m_awready = 2'b01;
    tbl[4].stim = s; tbl[4].exp = e;

    s = zs(); e = ze();
    s.r_en = 2'b10; s.r_sel = 2'b00; s.rdata_s[1] = 32'hCAFEF00D; s.rid_s[1] = 4'd3;
    s.rvalid_s = 2'b10; s.rready_m = 2'b01;
    e.m_rdata[0] = 32'hCAFEF00D; e.m_rid[0] = 4'd3; e.m_rvalid = 2'b01; e.s_rready = 2'b10;
    tbl[5].stim = s; tbl[5].exp = e;

    s = zs(); e = ze();
    s.aw_en = 2'b11; s.aw_sel = 2'b01; s.awvalid = 2'b11; s.awready_s = 2'b11;
    s.awaddr[0] = 32'h0000_0100; s.awaddr[1] = 32'h0000_0200;
    e.s_awvalid = 2'b11; e.s_awaddr[0] = 32'h0000_0200; e.s_awaddr[1] = 32'h0000_0100;
    e.m_awready = 2'b11;
    tbl[6].stim = s; tbl[6].exp = e;

    s = zs(); e = ze();
    s.aw_en = 2'b01; s.aw_sel = 2'b01; s.w_en = 2'b01; s.w_sel = 2'b00;
    s.ar_en = 2'b01; s.ar_sel = 2'b01;
    s.awvalid = 2'b01; s.wvalid = 2'b01; s.arvalid = 2'b01;
    s.awaddr[0] = 32'h11; s.wdata[0] = 32'h22; s.araddr[0] = 32'h33;
    s.awready_s = 2'b11; s.wready_s = 2'b11; s.arready_s = 2'b11;
    e.s_awvalid = 2'b10; e.s_awaddr[1] = 32'h11; e.m_awready = 2'b01;
    e.s_wvalid = 2'b01; e.s_wdata[0] = 32'h22; e.m_wready = 2'b01;
    e.s_arvalid = 2'b10; e.s_araddr[1] = 32'h33; e.m_arready = 2'b01;
    tbl[7].stim = s; tbl[7].exp = e;

    // ---- reset: outputs forced low even with live, conflicting traffic ----
    exp_conf = '0;
    s = tbl[0].stim;
    s.aw_en = 2'b11; s.aw_sel = 2'b00;
    drive(s);
    #2;
    cmp("rst S0_AWVALID", 0, 64'(s0.AWVALID), 64'd0);
    cmp("rst M0_AWREADY", 0, 64'(m0.AWREADY), 64'd0);
    check_model("rst");
    tick();
    tick();

    // deassert between edges: routing is live without waiting for a clock
    #2;
    ARESETn = 1'b1;
    #1;
    cmp("rel S0_AWVALID", 0, 64'(s0.AWVALID), 64'd1);
    cmp("rel S0_AWADDR", 0, 64'(s0.AWADDR), 64'hAABBCCDD);
    check_model("rel");
    tick();

    // reset the flags seeded above, then start the table from clean state
    #1; ARESETn = 1'b0; exp_conf = '0; #1; ARESETn = 1'b1;
    drive(zs());
    tick();

    // ---- table ----
    for (int k = 0; k < NT; k++) begin
      drive(tbl[k].stim);
      #2;
      for (int j = 0; j < 2; j++) begin
        cmp("t S_AWVALID", k * 10 + j, 64'(a_s_awvalid[j]), 64'(tbl[k].exp.s_awvalid[j]));
        cmp("t S_AWADDR",  k * 10 + j, 64'(a_s_awaddr[j]),  64'(tbl[k].exp.s_awaddr[j]));
        cmp("t M_AWREADY", k * 10 + j, 64'(a_awready[j]),   64'(tbl[k].exp.m_awready[j]));
        cmp("t S_WVALID",  k * 10 + j, 64'(a_s_wvalid[j]),  64'(tbl[k].exp.s_wvalid[j]));
        cmp("t S_WDATA",   k * 10 + j, 64'(a_s_wdata[j]),   64'(tbl[k].exp.s_wdata[j]));
        cmp("t M_WREADY",  k * 10 + j, 64'(a_wready[j]),    64'(tbl[k].exp.m_wready[j]));
        cmp("t S_ARVALID", k * 10 + j, 64'(a_s_arvalid[j]), 64'(tbl[k].exp.s_arvalid[j]));
        cmp("t S_ARADDR",  k * 10 + j, 64'(a_s_araddr[j]),  64'(tbl[k].exp.s_araddr[j]));
        cmp("t M_ARREADY", k * 10 + j, 64'(a_arready[j]),   64'(tbl[k].exp.m_arready[j]));
        cmp("t M_RVALID",  k * 10 + j, 64'(a_rvalid[j]),    64'(tbl[k].exp.m_rvalid[j]));
        cmp("t M_RDATA",   k * 10 + j, 64'(a_rdata[j]),     64'(tbl[k].exp.m_rdata[j]));
        cmp("t M_RID",     k * 10 + j, 64'(a_rid[j]),       64'(tbl[k].exp.m_rid[j]));
        cmp("t S_RREADY",  k * 10 + j, 64'(a_s_rready[j]),  64'(tbl[k].exp.s_rready[j]));
      end
      check_model("tbl");
      tick();
    end

`ifdef CROSSBAR_CONFLICT_DET_EN
    // ---- sticky conflict flag sequence ----
    #1; ARESETn = 1'b0; exp_conf = '0; #1;
    cmp("conf rst", 0, 64'({S1_conflict, S0_conflict}), 64'd0);
    ARESETn = 1'b1;
    drive(tbl[6].stim);             // cross traffic: no conflict
    tick();
    cmp("conf cross", 0, 64'({S1_conflict, S0_conflict}), 64'd0);
    drive(tbl[4].stim);             // both masters AW -> S1
    tick();
    cmp("conf set", 0, 64'({S1_conflict, S0_conflict}), 64'b10);
    drive(zs());
    tick();
    tick();
    cmp("conf hold", 0, 64'({S1_conflict, S0_conflict}), 64'b10);
    #1; ARESETn = 1'b0; exp_conf = '0; #1;
    cmp("conf clr", 0, 64'({S1_conflict, S0_conflict}), 64'd0);
    ARESETn = 1'b1;
    tick();
`endif

    // ---- async reset mid-transfer ----
    drive(tbl[0].stim);
    #2;
    ARESETn = 1'b0;
    exp_conf = '0;
    #1;
    cmp("mid S0_AWVALID", 0, 64'(s0.AWVALID), 64'd0);
    cmp("mid M0_WREADY", 0, 64'(m0.WREADY), 64'd0);
    check_model("mid");
    #2;
    ARESETn = 1'b1;
    #1;
    cmp("resume S0_WDATA", 0, 64'(s0.WDATA), 64'h12345678);
    check_model("resume");
    tick();

    // ---- randomized traffic ----
    for (int n = 0; n < 400; n++) begin
      drive(rand_stim());
      #2;
      check_model("rnd");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/crossbar_2x2.md
CROSSBAR_2X2 -- requirements
Module: crossbar_2x2

Interface
REQ-001 Parameters SHALL be BUS_WIDTH (default 32, data width); ID_WIDTH (default 4, transaction ID width); ADDR_WIDTH (default 32, address width); SEL_W is local, fixed at 1, and selects slave or master index.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 ACLK  in  1  sole clock, rising edge.
REQ-004 ARESETn  in  1  asynchronous active-low reset.
REQ-005 For i in {0,1}, the write-address ports SHALL be M{i}_AWID in ID_WIDTH, M{i}_AWADDR in ADDR_WIDTH, M{i}_AWVALID in 1, and M{i}_AWREADY out 1.
REQ-006 For i in {0,1}, the write-data ports SHALL be M{i}_WDATA in BUS_WIDTH, M{i}_WVALID in 1, and M{i}_WREADY out 1.
REQ-007 For i in {0,1}, the read-address ports SHALL be M{i}_ARID in ID_WIDTH, M{i}_ARADDR in ADDR_WIDTH, M{i}_ARVALID in 1, and M{i}_ARREADY out 1.
REQ-008 For i in {0,1}, the master response ports SHALL be M{i}_BID out ID_WIDTH, M{i}_BRESP out 2, M{i}_BVALID out 1, and M{i}_BREADY in 1.
REQ-009 For i in {0,1}, the master read-data ports SHALL be M{i}_RID out ID_WIDTH, M{i}_RDATA out BUS_WIDTH, M{i}_RRESP out 2, M{i}_RVALID out 1, and M{i}_RREADY in 1.
REQ-010 For j in {0,1}, the slave request ports SHALL mirror M{i} with directions reversed: S{j}_AWID/AWADDR/AWVALID out, S{j}_AWREADY in; S{j}_WDATA/WVALID out, S{j}_WREADY in; S{j}_ARID/ARADDR/ARVALID out, S{j}_ARREADY in.
REQ-011 For j in {0,1}, the slave response ports SHALL be S{j}_BID/BRESP/BVALID in, S{j}_BREADY out; S{j}_RID/RDATA/RRESP/RVALID in, S{j}_RREADY out.
REQ-012 For i in {0,1}, the master route controls SHALL be M{i}_write_addr_sel/_en, M{i}_write_data_sel/_en and M{i}_read_addr_sel/_en, all in; sel is SEL_W (target slave), en is 1 (route enable).
REQ-013 For j in {0,1}, the slave route controls SHALL be S{j}_write_resp_sel/_en and S{j}_read_data_sel/_en, all in; sel is SEL_W (target master), en is 1.

Function
REQ-014 All routing SHALL be purely combinational with zero-cycle latency; no channel payload is registered.
REQ-015 When M{i}_write_addr_en=1 and M{i}_write_addr_sel=j and master i wins, the bus SHALL drive S{j}_AW{ID,ADDR,VALID} = M{i}_AW{ID,ADDR,VALID} and M{i}_AWREADY = S{j}_AWREADY; the W and AR channels SHALL behave identically under their own sel/en.
REQ-016 When S{j}_write_resp_en=1 and S{j}_write_resp_sel=i and slave j wins, the bus SHALL drive M{i}_B* = S{j}_B* and S{j}_BREADY = M{i}_BREADY; the R channel SHALL behave identically under read_data_sel/en.
REQ-017 Arbitration SHALL be fixed priority per channel: when both sources target the same destination, index 0 wins and the loser's READY is driven 0.
REQ-018 An unrouted destination SHALL drive VALID=0 and ID/ADDR/DATA/RESP=0.
REQ-019 An unrouted or losing source SHALL see READY=0.
REQ-020 Each channel SHALL route independently; AW, W and AR of the same master may target different slaves simultaneously.
REQ-021 The crossbar SHALL NOT generate, drop or reorder beats; VALID/READY handshake semantics are passed through unchanged.

Reset
REQ-022 While ARESETn=0, all VALID and READY outputs SHALL be forced to 0 and payload outputs to 0, regardless of controls.
REQ-023 Reset assertion mid-transfer SHALL take effect immediately and asynchronously; on deassertion, routing SHALL resume combinationally with no recovery cycle.
REQ-024 All state (conflict flags) SHALL clear to 0 asynchronously on reset.

Configuration
REQ-025 With CROSSBAR_CONFLICT_DET_EN defined, the block SHALL add outputs S{j}_conflict (out, 1) for j in {0,1}; each is a sticky flag set on the ACLK rising edge whenever both masters are enabled on any request channel toward slave j, and cleared only by reset.
REQ-026 Without CROSSBAR_CONFLICT_DET_EN, those ports and registers SHALL be absent and the block SHALL be fully combinational apart from the reset gating.

Structure
REQ-027 A shared package crossbar_pkg SHALL hold NUM_MASTERS=2, NUM_SLAVES=2, SEL_W, and the 2-bit response encoding constants (OKAY=0, SLVERR=2).
REQ-028 One sub-module xbar_chan_mux SHALL implement the generic 2-source/2-destination channel mux with fixed priority, instantiated 5 times: AW, W and AR forward; B and R reverse.

Verification
REQ-029 Reset low with M0_AWVALID=1, en=1: S0_AWVALID=0, M0_AWREADY=0.
REQ-030 M0 write_addr/write_data en=1, sel=0, AWADDR=0xAABBCCDD, WDATA=0x12345678, valids=1, S0 ready=1: S0_AWADDR=0xAABBCCDD, S0_WDATA=0x12345678, S0_AWVALID=S0_WVALID=1, M0_AWREADY=M0_WREADY=1; valids dropped lead to S0 valids 0 the same cycle.
REQ-031 M0 read_addr en=1, sel=0, ARADDR=0xDEADBEEF, ARVALID=1: S0_ARADDR=0xDEADBEEF, S0_ARVALID=1, M0_ARREADY=1; with en=0 the result is S0_ARVALID=0, S0_ARADDR=0.
REQ-032 M0 and M1 both AW en, sel=1, M1_AWADDR=0x1000: S1 carries M0's address, M1_AWREADY=0; with the macro defined, S1_conflict=1 after the next ACLK edge and holds until reset.
REQ-033 S1 read_data en=1, sel=0, RDATA=0xCAFEF00D, RID=3, RVALID=1, M0_RREADY=1: M0_RDATA=0xCAFEF00D, M0_RID=3, S1_RREADY=1, M1_RVALID=0.
REQ-034 Cross traffic with M0 AW to S1 and M1 AW to S0 simultaneously: both routed, both AWREADY=1, no conflict flagged.
